aes_job_arbiter: RTL and testbench
==================================

# aes_job_arbiter

Round-robin job scheduler that shares one AES-256 crypto engine (the SPI master plus encryption or decryption unit pair) between two independent requesters. Each requester submits a message, key and direction over a valid/ready handshake. The arbiter grants one job at a time, latches its operands, pulses the engine start, waits for completion, then returns the 128-bit result to the granted requester over a response handshake. It sits between the host-side job sources and the engine's msg/key/valid inputs.

## Interface
- MSG_W, 128, message/result width
- KEY_W, 256, key width (nk=8)
- TIMEOUT_CYCLES, 20000, max WAIT cycles before abort (only with timeout macro)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- reqN_valid  in  1  job request, N = 0,1
- reqN_ready  out  1  one-cycle accept pulse, N = 0,1
- reqN_mode  in  1  0 = encrypt, 1 = decrypt
- reqN_msg  in  MSG_W  plaintext or ciphertext
- reqN_key  in  KEY_W  key
- rspN_valid  out  1  result available to requester N
- rspN_ready  in  1  requester N consumes result
- rsp_data  out  MSG_W  result, shared by both response channels
- rsp_err  out  1  result invalid (timeout)
- eng_start  out  1  one-cycle start pulse to engine
- eng_mode, eng_msg, eng_key  out  1/MSG_W/KEY_W  latched operands, stable from start to done
- eng_done  in  1  engine completion pulse
- eng_result  in  MSG_W  engine output, sampled on eng_done
- eng_abort  out  1  one-cycle abort pulse on timeout
- busy  out  1  state != IDLE
- grant_id  out  1  channel currently owning the engine

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No valid request: stay in IDLE.
  - Exactly one reqN_valid: grant N.
  - Both valid: grant the channel not equal to last_grant.
  - On grant: assert reqN_ready for 1 cycle; latch mode, msg and key into eng_*; set grant_id = last_grant = N; go to ISSUE.
- ISSUE: eng_start = 1 for exactly one cycle; clear timeout counter; go to WAIT.
- WAIT: on eng_done, capture eng_result into rsp_data, set rsp_err = 0, go to RESP. eng_done in any other state is ignored.
- RESP: rsp{grant_id}_valid = 1 and held until rsp{grant_id}_ready. On ready, go to IDLE. The other channel's rsp_valid stays 0.
- Requests are never accepted outside IDLE, so ready is 0 in ISSUE, WAIT and RESP. Requesters must hold valid and operands until ready.
- Operand registers change only on grant.

## Timing
- Reset values: all ready/valid/start/abort = 0, rsp_err = 0, rsp_data = 0, eng_mode/msg/key = 0, busy = 0, grant_id = 0, last_grant = 1 (ch0 wins the first tie). Timeout counter = 0, state IDLE.
- Accept at cycle T (valid & ready). eng_start at T+1. WAIT from T+2.
- eng_done at cycle D: rspN_valid from D+1.
- Minimum request-to-response latency is 3 cycles plus engine latency.
- Response consumed at cycle R: IDLE at R+1. Next grant at earliest R+1; back-to-back jobs lose 1 idle cycle.
- eng_done in the same cycle as the timeout limit: done wins, result valid, no abort.
- Reset asserted in any state: next edge returns to IDLE with reset values. A pending response is lost and eng_abort is not pulsed.

## Configuration
- AES_ARB_TIMEOUT_EN defined: a 15-bit counter increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without eng_done: pulse eng_abort for 1 cycle, rsp_data = 0, rsp_err = 1, go to RESP.
  - Late eng_done after abort is ignored.
- Not defined: no counter; WAIT persists until eng_done. rsp_err and eng_abort are tied to 0.

## Test plan
- Single encrypt:
  - Stimulus: ch0 mode=0, msg 00112233445566778899aabbccddeeff, key 000102…1e1f; engine model returns 8ea2b7ca516745bfeafc49904b496089 after 50 cycles.
  - Required: ready at T, start at T+1, rsp0_valid with that data and err=0. rsp1_valid stays 0.
- Decrypt round trip:
  - Stimulus: ch1 mode=1, msg 8ea2b7ca516745bfeafc49904b496089, same key.
  - Required: rsp1 data 00112233445566778899aabbccddeeff, grant_id=1.
- Contention:
  - Stimulus: both valid from reset, continuously, with 4 jobs.
  - Required: grant order 0,1,0,1; never two ready in the same cycle.
- Backpressure:
  - Stimulus: rsp0_ready held low for 100 cycles.
  - Required: rsp0_valid and rsp_data stable, ch1 not accepted until release; IDLE 1 cycle after release.
- Timeout (macro on, TIMEOUT_CYCLES=64):
  - Stimulus: engine never signals done.
  - Required: eng_abort pulse after 64 WAIT cycles, rsp err=1, data=0.
  - Macro off: busy stays 1 indefinitely.
- Reset mid-WAIT:
  - Stimulus: rst low for 1 cycle during WAIT.
  - Required: IDLE and all outputs at reset values next cycle. A subsequent eng_done is ignored, and a new ch0 job completes normally.

Source files
------------

// File: rtl/aes_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : aes_job_arbiter
// Description : Round-robin scheduler sharing one AES-256 engine between two
//               requesters: grant, latch operands, start, wait, respond.
//               Optional WAIT timeout/abort enabled by AES_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_job_arbiter #(
    parameter int MSG_W          = 128,
    parameter int KEY_W          = 256,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_mode,
    input  logic [MSG_W-1:0] req0_msg,
    input  logic [KEY_W-1:0] req0_key,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_mode,
    input  logic [MSG_W-1:0] req1_msg,
    input  logic [KEY_W-1:0] req1_key,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [MSG_W-1:0] rsp_data,
    output logic             rsp_err,

    output logic             eng_start,
    output logic             eng_mode,
    output logic [MSG_W-1:0] eng_msg,
    output logic [KEY_W-1:0] eng_key,
    input  logic             eng_done,
    input  logic [MSG_W-1:0] eng_result,
    output logic             eng_abort,

    output logic             busy,
    output logic             grant_id
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_last_grant;
    logic               r_grant;
    logic               r_req0_ready;
    logic               r_req1_ready;
    logic               r_rsp0_valid;
    logic               r_rsp1_valid;
    logic [MSG_W-1:0]   r_rsp_data;
    logic               r_eng_start;
    logic               r_eng_mode;
    logic [MSG_W-1:0]   r_eng_msg;
    logic [KEY_W-1:0]   r_eng_key;

    logic               w_any_req;
    logic               w_pick;
    logic               w_pick_mode;
    logic [MSG_W-1:0]   w_pick_msg;
    logic [KEY_W-1:0]   w_pick_key;
    logic               w_rsp_ack;

    // On a tie the channel that did not win last time is chosen.
    always_comb begin
        w_any_req = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            w_pick = ~r_last_grant;
        end else begin
            w_pick = req1_valid;
        end
        w_pick_mode = w_pick ? req1_mode : req0_mode;
        w_pick_msg  = w_pick ? req1_msg  : req0_msg;
        w_pick_key  = w_pick ? req1_key  : req0_key;
        w_rsp_ack   = r_grant ? rsp1_ready : rsp0_ready;
    end

`ifdef AES_ARB_TIMEOUT_EN
    localparam logic [14:0] c_timeout_last = 15'(TIMEOUT_CYCLES - 1);

    logic [14:0] r_wait_cnt;
    logic        r_rsp_err;
    logic        r_eng_abort;
    logic        w_timeout;

    assign w_timeout = (r_wait_cnt == c_timeout_last);
`else
    logic [14:0] w_unused_timeout;
    assign w_unused_timeout = 15'(TIMEOUT_CYCLES);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_req0_ready <= 1'b0;
            r_req1_ready <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp_data   <= '0;
            r_eng_start  <= 1'b0;
            r_eng_mode   <= 1'b0;
            r_eng_msg    <= '0;
            r_eng_key    <= '0;
`ifdef AES_ARB_TIMEOUT_EN
            r_wait_cnt   <= '0;
            r_rsp_err    <= 1'b0;
            r_eng_abort  <= 1'b0;
`endif
        end else begin
            r_req0_ready <= 1'b0;
            r_req1_ready <= 1'b0;
            r_eng_start  <= 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
            r_eng_abort  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_req0_ready <= ~w_pick;
                        r_req1_ready <= w_pick;
                        r_eng_mode   <= w_pick_mode;
                        r_eng_msg    <= w_pick_msg;
                        r_eng_key    <= w_pick_key;
                        r_grant      <= w_pick;
                        r_last_grant <= w_pick;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_eng_start <= 1'b1;
`ifdef AES_ARB_TIMEOUT_EN
                    r_wait_cnt  <= '0;
`endif
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    // A completion on the limit cycle still wins over the abort.
                    if (eng_done) begin
                        r_rsp_data   <= eng_result;
                        r_rsp0_valid <= ~r_grant;
                        r_rsp1_valid <= r_grant;
`ifdef AES_ARB_TIMEOUT_EN
                        r_rsp_err    <= 1'b0;
`endif
                        r_state      <= S_RESP;
                    end
`ifdef AES_ARB_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_eng_abort  <= 1'b1;
                        r_rsp_data   <= '0;
                        r_rsp_err    <= 1'b1;
                        r_rsp0_valid <= ~r_grant;
                        r_rsp1_valid <= r_grant;
                        r_state      <= S_RESP;
                    end else begin
                        r_wait_cnt   <= r_wait_cnt + 15'd1;
                    end
`endif
                end
                S_RESP: begin
                    if (w_rsp_ack) begin
                        r_rsp0_valid <= 1'b0;
                        r_rsp1_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req0_ready = r_req0_ready;
    assign req1_ready = r_req1_ready;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp_data   = r_rsp_data;
    assign eng_start  = r_eng_start;
    assign eng_mode   = r_eng_mode;
    assign eng_msg    = r_eng_msg;
    assign eng_key    = r_eng_key;
    assign busy       = (r_state != S_IDLE);
    assign grant_id   = r_grant;

`ifdef AES_ARB_TIMEOUT_EN
    assign rsp_err    = r_rsp_err;
    assign eng_abort  = r_eng_abort;
`else
    assign rsp_err    = 1'b0;
    assign eng_abort  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_job_arbiter
// Description : Self-checking bench for aes_job_arbiter with an engine model
//               and a job-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_job_arbiter;

    localparam logic [127:0] c_p0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_c0 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] c_k0 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic         rst = 1'b0;
    logic         req0_valid = 1'b0, req0_mode = 1'b0, req1_valid = 1'b0, req1_mode = 1'b0;
    logic [127:0] req0_msg = '0, req1_msg = '0;
    logic [255:0] req0_key = '0, req1_key = '0;
    logic         rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic         req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err;
    logic [127:0] rsp_data, eng_msg;
    logic [255:0] eng_key;
    logic         eng_start, eng_mode, eng_abort, busy, grant_id;
    logic         eng_done = 1'b0;
    logic [127:0] eng_result = '0;

    int checks = 0;
    int errors = 0;

    aes_job_arbiter #(.MSG_W(128), .KEY_W(256), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
        .req0_msg(req0_msg), .req0_key(req0_key),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
        .req1_msg(req1_msg), .req1_key(req1_key),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .eng_start(eng_start), .eng_mode(eng_mode), .eng_msg(eng_msg), .eng_key(eng_key),
        .eng_done(eng_done), .eng_result(eng_result), .eng_abort(eng_abort),
        .busy(busy), .grant_id(grant_id)
    );

    // Stand-in for the AES engine: the known test vector pair, otherwise a
    // cheap keyed mixing function so every job has a distinct result.
    function automatic logic [127:0] ref_aes(input logic m, input logic [127:0] msg, input logic [255:0] key);
        if (key == c_k0 && !m && msg == c_p0) return c_c0;
        if (key == c_k0 && m && msg == c_c0) return c_p0;
        return {msg[63:0], msg[127:64]} ^ key[127:0] ^ key[255:128] ^ {128{m}};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [255:0] rnd256();
        return {rnd128(), rnd128()};
    endfunction

    int           eng_lat  = 50;
    bit           eng_mute = 1'b0;
    int           eng_cnt  = 0;
    logic         cap_mode;
    logic [127:0] cap_msg;
    logic [255:0] cap_key;

    always @(negedge clk) begin
        eng_done   = 1'b0;
        eng_result = rnd128();
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0 && !eng_mute) begin
                eng_done   = 1'b1;
                eng_result = ref_aes(cap_mode, cap_msg, cap_key);
            end
        end
        if (eng_start === 1'b1) begin
            cap_mode = eng_mode;
            cap_msg  = eng_msg;
            cap_key  = eng_key;
            eng_cnt  = eng_lat;
        end
    end

    function automatic bit at_reset_vals();
        return req0_ready === 1'b0 && req1_ready === 1'b0 && rsp0_valid === 1'b0 &&
               rsp1_valid === 1'b0 && eng_start === 1'b0 && eng_abort === 1'b0 &&
               rsp_err === 1'b0 && busy === 1'b0 && grant_id === 1'b0 &&
               rsp_data === '0 && eng_mode === 1'b0 && eng_msg === '0 && eng_key === '0;
    endfunction

    function automatic logic rsp_v(input int ch);
        return (ch == 0) ? rsp0_valid : rsp1_valid;
    endfunction

    task automatic drive_req(input int ch, input logic v, input logic m, input logic [127:0] msg, input logic [255:0] key);
        if (ch == 0) begin
            req0_valid = v; req0_mode = m; req0_msg = msg; req0_key = key;
        end else begin
            req1_valid = v; req1_mode = m; req1_msg = msg; req1_key = key;
        end
    endtask

    // Presents one job, waits for its accept, then scrambles the operands so
    // that late sampling of the request bus would be caught.
    task automatic submit(input int ch, input logic m, input logic [127:0] msg, input logic [255:0] key, output int t);
        t = -1;
        drive_req(ch, 1'b1, m, msg, key);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
                t = cyc;
                break;
            end
        end
        checks++;
        if (t < 0) begin
            errors++;
            $display("FAIL accept_wait ch%0d: no ready within 200 cycles", ch);
            drive_req(ch, 1'b0, 1'b0, '0, '0);
            return;
        end
        checks++;
        if ({req1_ready, req0_ready} !== ((ch == 0) ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL ready_route ch%0d: ready={%b,%b} required one-hot ch%0d", ch, req1_ready, req0_ready, ch);
        end
        drive_req(ch, 1'b0, $urandom_range(0, 1), rnd128(), rnd256());
        @(negedge clk);
        checks++;
        if (eng_start !== 1'b1) begin
            errors++;
            $display("FAIL start_at_T+1 ch%0d: eng_start=%b required 1", ch, eng_start);
        end
        checks++;
        if (eng_mode !== m || eng_msg !== msg || eng_key !== key) begin
            errors++;
            $display("FAIL operand_latch ch%0d: eng_mode=%b eng_msg=%h required mode=%b msg=%h", ch, eng_mode, eng_msg, m, msg);
        end
    endtask

    task automatic do_job(input int ch, input logic m, input logic [127:0] msg, input logic [255:0] key, input int lat, input int hold);
        int t, r;
        bit stable;
        logic [127:0] exp;
        exp     = ref_aes(m, msg, key);
        eng_lat = lat;
        submit(ch, m, msg, key, t);
        if (t < 0) return;
        r = -1;
        for (int i = 0; i < lat + 50; i++) begin
            if (rsp_v(ch) === 1'b1) begin
                r = cyc;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (r != t + 2 + lat) begin
            errors++;
            $display("FAIL rsp_latency ch%0d: rsp_valid at cycle %0d required %0d", ch, r, t + 2 + lat);
        end
        if (r < 0) return;
        checks++;
        if (rsp_data !== exp || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL rsp_data ch%0d: data=%h err=%b required data=%h err=0", ch, rsp_data, rsp_err, exp);
        end
        checks++;
        if (grant_id !== ch[0] || rsp_v(1 - ch) !== 1'b0) begin
            errors++;
            $display("FAIL rsp_route ch%0d: grant_id=%b other_valid=%b required grant_id=%0d other_valid=0", ch, grant_id, rsp_v(1 - ch), ch);
        end
        stable = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (rsp_v(ch) !== 1'b1 || rsp_data !== exp || rsp_v(1 - ch) !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0)
                stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL rsp_hold ch%0d: response changed during %0d stall cycles, required stable", ch, hold);
        end
        if (ch == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_rsp ch%0d: busy=%b rsp_valid={%b,%b} required 0", ch, busy, rsp1_valid, rsp0_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req0_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (!at_reset_vals()) begin
            errors++;
            $display("FAIL reset_values: busy=%b ready={%b,%b} start=%b grant=%b data=%h required all 0", busy, req1_ready, req0_ready, eng_start, grant_id, rsp_data);
        end
        req0_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (!at_reset_vals()) begin
            errors++;
            $display("FAIL reset_release: busy=%b ready={%b,%b} required idle reset values", busy, req1_ready, req0_ready);
        end
    endtask

    // Both channels request continuously; the reference is strict alternation
    // starting from channel 0 after reset.
    task automatic test_contention();
        logic         ops_m[2];
        logic [127:0] ops_msg[2];
        logic [255:0] ops_key[2];
        logic [127:0] exp;
        int           last, g, r;
        last = 1;
        eng_lat = 8;
        for (int c = 0; c < 2; c++) begin
            ops_m[c] = $urandom_range(0, 1); ops_msg[c] = rnd128(); ops_key[c] = rnd256();
            drive_req(c, 1'b1, ops_m[c], ops_msg[c], ops_key[c]);
        end
        for (int j = 0; j < 4; j++) begin
            g = -1;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
                    checks++; errors++;
                    $display("FAIL dual_ready job%0d: both ready asserted, required at most one", j);
                end
                if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
                    g = (req0_ready === 1'b1) ? 0 : 1;
                    break;
                end
            end
            checks++;
            if (g != 1 - last) begin
                errors++;
                $display("FAIL grant_order job%0d: granted ch%0d required ch%0d", j, g, 1 - last);
            end
            if (g < 0) break;
            last = g;
            exp  = ref_aes(ops_m[g], ops_msg[g], ops_key[g]);
            ops_m[g] = $urandom_range(0, 1); ops_msg[g] = rnd128(); ops_key[g] = rnd256();
            drive_req(g, 1'b1, ops_m[g], ops_msg[g], ops_key[g]);
            r = -1;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (rsp_v(g) === 1'b1) begin r = cyc; break; end
            end
            checks++;
            if (r < 0 || rsp_data !== exp || rsp_v(1 - g) !== 1'b0) begin
                errors++;
                $display("FAIL contention_rsp job%0d: ch%0d valid_seen=%0d data=%h required %h", j, g, r >= 0, rsp_data, exp);
            end
            if (g == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
            @(negedge clk);
            rsp0_ready = 1'b0;
            rsp1_ready = 1'b0;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int t, r, t1;
        bit stable;
        logic [127:0] exp, exp1, msg1;
        logic [255:0] key1;
        msg1 = rnd128();
        key1 = rnd256();
        exp  = ref_aes(1'b0, c_p0, c_k0);
        exp1 = ref_aes(1'b1, msg1, key1);
        eng_lat = 10;
        submit(0, 1'b0, c_p0, c_k0, t);
        drive_req(1, 1'b1, 1'b1, msg1, key1);
        r = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp0_valid === 1'b1) begin r = cyc; break; end
        end
        stable = (r >= 0);
        repeat (100) begin
            @(negedge clk);
            if (rsp0_valid !== 1'b1 || rsp_data !== exp || req1_ready !== 1'b0 || rsp1_valid !== 1'b0)
                stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL backpressure_hold: rsp0_valid=%b data=%h req1_ready=%b required 1/%h/0", rsp0_valid, rsp_data, req1_ready, exp);
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: busy=%b rsp0_valid=%b required 0/0 one cycle after release", busy, rsp0_valid);
        end
        t1 = cyc + 1;
        eng_lat = 6;
        submit(1, 1'b1, msg1, key1, t);
        checks++;
        if (t != t1) begin
            errors++;
            $display("FAIL backpressure_next_grant: ch1 accepted at cycle %0d required %0d", t, t1);
        end
        for (int i = 0; i < 50 && rsp1_valid !== 1'b1; i++) @(negedge clk);
        checks++;
        if (rsp1_valid !== 1'b1 || rsp_data !== exp1) begin
            errors++;
            $display("FAIL backpressure_ch1_rsp: valid=%b data=%h required 1/%h", rsp1_valid, rsp_data, exp1);
        end
        rsp1_ready = 1'b1;
        @(negedge clk);
        rsp1_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int j = 0; j < 12; j++)
            do_job($urandom_range(0, 1), $urandom_range(0, 1), rnd128(), rnd256(),
                   $urandom_range(1, 20), $urandom_range(0, 4));
    endtask

`ifdef AES_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int t, a;
        eng_mute = 1'b1;
        eng_lat  = 90;
        submit(0, 1'b0, rnd128(), rnd256(), t);
        a = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (eng_abort === 1'b1) begin a = cyc; break; end
        end
        checks++;
        if (a < t + 64 || a > t + 67) begin
            errors++;
            $display("FAIL timeout_abort: abort at cycle %0d required about %0d", a, t + 66);
        end
        checks++;
        if (rsp0_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== '0) begin
            errors++;
            $display("FAIL timeout_rsp: valid=%b err=%b data=%h required 1/1/0", rsp0_valid, rsp_err, rsp_data);
        end
        @(negedge clk);
        checks++;
        if (eng_abort !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: eng_abort=%b second cycle required 0", eng_abort);
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
        repeat (40) @(negedge clk);
        eng_mute = 1'b0;
    endtask
`else
    task automatic test_hang();
        int t;
        bit held;
        eng_mute = 1'b1;
        eng_lat  = 50;
        submit(0, 1'b0, rnd128(), rnd256(), t);
        held = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (busy !== 1'b1 || rsp0_valid !== 1'b0 || eng_abort !== 1'b0) held = 1'b0;
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL hang_busy: busy=%b rsp0_valid=%b abort=%b required 1/0/0 without done", busy, rsp0_valid, eng_abort);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        eng_mute = 1'b0;
        @(negedge clk);
    endtask
`endif

    task automatic test_reset_mid_wait();
        int t;
        bit quiet;
        eng_lat = 30;
        submit(1, 1'b1, rnd128(), rnd256(), t);
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || grant_id !== 1'b1) begin
            errors++;
            $display("FAIL mid_wait_busy: busy=%b grant_id=%b required 1/1", busy, grant_id);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++;
        if (!at_reset_vals()) begin
            errors++;
            $display("FAIL mid_wait_reset: busy=%b grant_id=%b rsp_valid={%b,%b} required reset values", busy, grant_id, rsp1_valid, rsp0_valid);
        end
        quiet = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL stale_done: busy=%b rsp_valid={%b,%b} required 0 after reset", busy, rsp1_valid, rsp0_valid);
        end
        do_job(0, 1'b0, rnd128(), rnd256(), 5, 0);
    endtask

    initial begin
        test_reset();
        test_contention();
        do_job(0, 1'b0, c_p0, c_k0, 50, 0);
        do_job(1, 1'b1, c_c0, c_k0, 50, 2);
        test_backpressure();
        test_random();
`ifdef AES_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_hang();
`endif
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
